tx_sym_sched: RTL and testbench
===============================

Name: tx_sym_sched

Overview:
- Symbol scheduler between the transmit byte FIFO and the IQ modulator.
- Pops byte pairs from the FIFO (first byte I, second byte Q) and presents them on i_mul/q_mul.
- Holds each pair for a programmable number of clocks.
- On FIFO starvation, drives an idle value and flags underrun; on stop, drains cleanly without losing a byte.

Parameters:
- DIV_W, 16, width of the symbol-period divider.
- IDLE_VAL, 8'h00, value driven on i_mul/q_mul when idle or underrunning.
- MIN_DIV, 4, floor applied to sym_div; the pair fetch needs 5 clocks.

Ports:
- clk  in  1  system clock (PLL c0); the only clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = stream symbols, 0 = drain and stop.
- sym_div  in  DIV_W  clocks per symbol minus 1; values below MIN_DIV are treated as MIN_DIV.
- fifo_empty  in  1  FIFO empty flag.
- fifo_q  in  8  FIFO read data, valid the clock after fifo_rd (non-showahead).
- fifo_rd  out  1  FIFO read request, single-cycle pulses.
- i_mul  out  8  in-phase multiplier to the modulator.
- q_mul  out  8  quadrature multiplier to the modulator.
- sym_stb  out  1  one-clock pulse when a new FIFO pair is loaded onto i_mul/q_mul.
- underrun  out  1  sticky; set when a symbol boundary finds no staged pair while run=1.
- underrun_clr  in  1  clears underrun.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: fifo_rd=0, i_mul=q_mul=IDLE_VAL, sym_stb=0, underrun=0, busy=0, cnt=0, stage_valid=0, state=IDLE.
- Reset mid-operation aborts immediately. Any partly fetched pair is dropped; the FIFO is cleared by the same rst.
- Symbol counter cnt (DIV_W bits):
  - Active in every state except IDLE.
  - A boundary is any clock with cnt==0.
  - At a boundary, cnt reloads max(sym_div, MIN_DIV); otherwise cnt decrements.
  - Symbol period = eff_div+1 clocks.
  - A change to sym_div takes effect at the next reload.
- States:
  - IDLE: cnt held at 0. When run=1 -> RD_I.
  - RD_I:
    - fifo_rd = !fifo_empty. If a read is issued -> CAP_I.
    - If run=0 and no read is issued -> WAIT_SYM.
    - If the FIFO is empty, stay in RD_I.
  - CAP_I: stage_i <= fifo_q -> RD_Q.
  - RD_Q: fifo_rd = !fifo_empty. Waits (regardless of run) until a read is issued -> CAP_Q.
  - CAP_Q: stage_q <= fifo_q; stage_valid <= 1 -> WAIT_SYM.
  - WAIT_SYM:
    - Waits for a boundary.
    - If run=1 at the boundary -> RD_I.
    - If run=0 at the boundary: if stage_valid, emit the pair and stay in WAIT_SYM; otherwise -> IDLE.
- Boundary action, in any non-IDLE state:
  - If stage_valid: i_mul<=stage_i, q_mul<=stage_q, sym_stb<=1 for one clock, stage_valid<=0.
  - Else if run=1: i_mul=q_mul<=IDLE_VAL and underrun<=1. The fetch in progress continues; the half-fetched I byte is retained.
  - Else: i_mul=q_mul<=IDLE_VAL with no flag.
- Leaving IDLE: cnt is 0, so the first boundary occurs immediately. The bench must see the underrun rule apply only while stage_valid=0 and run=1.
  - Exception: no underrun is flagged on boundaries that occur before the first pair has ever been staged since IDLE.
- Latency: run sampled high at edge E0 with the FIFO non-empty gives:
  - fifo_rd high in E0–E1 and E2–E3.
  - First pair appears on i_mul/q_mul at E5; sym_stb high E5–E6.
- Back-to-back streaming with eff_div>=4 and the FIFO never empty: no idle symbols, exactly 2 fifo_rd pulses per symbol.
- fifo_rd is never asserted while fifo_empty=1, and never in two consecutive clocks.
- underrun: set has priority over underrun_clr in the same clock.

Test Plan:
1. Reset, load FIFO with 0x11,0x22,0x33,0x44; sym_div=9, run=1 -> (0x11,0x22) at E5 with sym_stb, (0x33,0x44) 10 clocks later. Then IDLE_VAL and underrun=1 at the following boundary.
2. 200 pairs, sym_div=4, FIFO kept non-empty -> one sym_stb every 5 clocks, 400 fifo_rd pulses, underrun stays 0, bytes in order.
3. sym_div=1 -> period clamped to 5 clocks; fifo_rd never on consecutive clocks and never with fifo_empty=1.
4. FIFO holds one byte (0x5A) only, run=1 -> block stalls in RD_Q, boundaries output IDLE_VAL with underrun=1. Push 0x6B -> next boundary emits (0x5A,0x6B).
5. Drop run while a pair is in CAP_I -> pair completes, is emitted at the next boundary, then IDLE, busy=0, no underrun, no extra reads.
6. Assert rst mid-stream, and underrun_clr coincident with a new underrun -> all outputs at reset values next clock; underrun remains 1 in the coincident case.

Source files
------------

// File: rtl/tx_sym_sched.sv
// Symbol scheduler: pops I/Q byte pairs from the TX FIFO and holds each on
// the modulator multipliers for one programmable symbol period.
module tx_sym_sched #(
    parameter int         DIV_W    = 16,
    parameter logic [7:0] IDLE_VAL = 8'h00,
    parameter int         MIN_DIV  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [DIV_W-1:0] sym_div,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_q,
    output logic             fifo_rd,
    output logic [7:0]       i_mul,
    output logic [7:0]       q_mul,
    output logic             sym_stb,
    output logic             underrun,
    input  logic             underrun_clr,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE, RD_I, CAP_I, RD_Q, CAP_Q, WAIT_SYM
    } state_t;

    localparam logic [DIV_W-1:0] MIN_DIV_W = DIV_W'(MIN_DIV);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, eff_div;
    logic [7:0]       stage_i_q, stage_i_d, stage_q_q, stage_q_d;
    logic [7:0]       i_q, i_d, q_q, q_d;
    logic             stage_valid_q, stage_valid_d;
    logic             primed_q, primed_d;
    logic             stb_q, stb_d;
    logic             urun_q, urun_d;
    logic             bnd;

    assign eff_div = (sym_div < MIN_DIV_W) ? MIN_DIV_W : sym_div;
    assign bnd     = (state_q != IDLE) && (cnt_q == '0);

    assign i_mul    = i_q;
    assign q_mul    = q_q;
    assign sym_stb  = stb_q;
    assign underrun = urun_q;
    assign busy     = (state_q != IDLE);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stage_i_d     = stage_i_q;
        stage_q_d     = stage_q_q;
        stage_valid_d = stage_valid_q;
        primed_d      = primed_q;
        i_d           = i_q;
        q_d           = q_q;
        stb_d         = 1'b0;
        urun_d        = urun_q;
        fifo_rd       = 1'b0;

        if (underrun_clr) begin
            urun_d = 1'b0;
        end

        if (state_q != IDLE) begin
            if (bnd) begin
                // Until the first pair is staged the period does not start,
                // so that pair lands on the earliest possible boundary.
                if (stage_valid_q || primed_q) begin
                    cnt_d = eff_div;
                end
                if (stage_valid_q) begin
                    i_d           = stage_i_q;
                    q_d           = stage_q_q;
                    stb_d         = 1'b1;
                    stage_valid_d = 1'b0;
                end else begin
                    i_d = IDLE_VAL;
                    q_d = IDLE_VAL;
                    if (run && primed_q) begin
                        urun_d = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                cnt_d    = '0;
                primed_d = 1'b0;
                if (run) begin
                    state_d = RD_I;
                end
            end
            RD_I: begin
                fifo_rd = !fifo_empty;
                if (!fifo_empty) begin
                    state_d = CAP_I;
                end else if (!run) begin
                    state_d = WAIT_SYM;
                end
            end
            CAP_I: begin
                stage_i_d = fifo_q;
                state_d   = RD_Q;
            end
            RD_Q: begin
                fifo_rd = !fifo_empty;
                if (!fifo_empty) begin
                    state_d = CAP_Q;
                end
            end
            CAP_Q: begin
                stage_q_d     = fifo_q;
                stage_valid_d = 1'b1;
                primed_d      = 1'b1;
                state_d       = WAIT_SYM;
            end
            WAIT_SYM: begin
                if (bnd) begin
                    if (run) begin
                        state_d = RD_I;
                    end else if (!stage_valid_q) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            stage_i_q     <= '0;
            stage_q_q     <= '0;
            stage_valid_q <= 1'b0;
            primed_q      <= 1'b0;
            i_q           <= IDLE_VAL;
            q_q           <= IDLE_VAL;
            stb_q         <= 1'b0;
            urun_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stage_i_q     <= stage_i_d;
            stage_q_q     <= stage_q_d;
            stage_valid_q <= stage_valid_d;
            primed_q      <= primed_d;
            i_q           <= i_d;
            q_q           <= q_d;
            stb_q         <= stb_d;
            urun_q        <= urun_d;
        end
    end

endmodule

// File: tb/tb_tx_sym_sched.sv
// Bench for tx_sym_sched: FIFO model, byte scoreboard, latency table and
// randomized streaming trials.
module tb_tx_sym_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [15:0] sym_div = 16'd9;
    logic        fifo_empty;
    logic [7:0]  fifo_q = 8'h00;
    logic        fifo_rd;
    logic [7:0]  i_mul, q_mul;
    logic        sym_stb, underrun, busy;
    logic        underrun_clr = 1'b0;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mem [0:8191];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int ep = 0;
    int rdcnt = 0;
    logic prev_rd = 1'b0;

    tx_sym_sched dut (
        .clk(clk), .rst(rst), .run(run), .sym_div(sym_div),
        .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rd(fifo_rd),
        .i_mul(i_mul), .q_mul(q_mul), .sym_stb(sym_stb),
        .underrun(underrun), .underrun_clr(underrun_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    // Non-showahead FIFO, cleared by the same reset
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (rst) rd_ptr <= wr_ptr;
        else if (fifo_rd && !fifo_empty) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_rd) begin
                rdcnt++;
                chk("rd_when_empty", int'(fifo_empty), 0);
                chk("rd_back_to_back", int'(prev_rd), 0);
            end
            if (sym_stb) begin
                chk("sb_i", int'(i_mul), int'(mem[ep]));
                chk("sb_q", int'(q_mul), int'(mem[ep+1]));
                ep += 2;
            end
        end
        prev_rd = fifo_rd;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic       run;
        logic       rd;
        logic       stb;
        logic [7:0] i;
        logic [7:0] q;
        logic       ur;
        logic       busy;
    } vec_t;

    vec_t tbl [26];

    task automatic do_reset();
        #1;
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        ep = wr_ptr;
    endtask

    task automatic wait_stb(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sym_stb && n < lim);
    endtask

    initial begin
        int n, snap, eff, pairs;

        for (int r = 0; r < 26; r++) begin
            tbl[r] = '{run: 1'b1, rd: 1'b0, stb: 1'b0, i: 8'h00,
                       q: 8'h00, ur: 1'b0, busy: 1'b1};
            if (r >= 5 && r < 15) begin
                tbl[r].i = 8'h11;
                tbl[r].q = 8'h22;
            end
            if (r >= 15 && r < 25) begin
                tbl[r].i = 8'h33;
                tbl[r].q = 8'h44;
            end
        end
        tbl[0].rd = 1'b1;
        tbl[2].rd = 1'b1;
        tbl[5].rd = 1'b1;
        tbl[7].rd = 1'b1;
        tbl[5].stb = 1'b1;
        tbl[15].stb = 1'b1;
        tbl[25].ur = 1'b1;

        // Latency and first-underrun table
        @(negedge clk);
        do_reset();
        chk("rst_busy", int'(busy), 0);
        chk("rst_i", int'(i_mul), 'h00);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        sym_div = 16'd9;
        for (int r = 0; r < 26; r++) begin
            run = tbl[r].run;
            @(negedge clk);
            chk($sformatf("t1 r%0d rd", r), int'(fifo_rd), int'(tbl[r].rd));
            chk($sformatf("t1 r%0d stb", r), int'(sym_stb), int'(tbl[r].stb));
            chk($sformatf("t1 r%0d i", r), int'(i_mul), int'(tbl[r].i));
            chk($sformatf("t1 r%0d q", r), int'(q_mul), int'(tbl[r].q));
            chk($sformatf("t1 r%0d ur", r), int'(underrun), int'(tbl[r].ur));
            chk($sformatf("t1 r%0d busy", r), int'(busy), int'(tbl[r].busy));
            #1;
        end

        // One byte only: stall in RD_Q, underrun, then complete the pair
        underrun_clr = 1'b1;
        push(8'h5A);
        @(negedge clk);
        chk("t4 clr", int'(underrun), 0);
        #1 underrun_clr = 1'b0;
        repeat (8) @(negedge clk);
        chk("t4 ur_before", int'(underrun), 0);
        @(negedge clk);
        chk("t4 ur_set", int'(underrun), 1);
        chk("t4 idle_i", int'(i_mul), 'h00);
        chk("t4 no_stb", int'(sym_stb), 0);
        #1 push(8'h6B);
        wait_stb(20, n);
        chk("t4 stb_delay", n, 10);
        chk("t4 i", int'(i_mul), 'h5A);
        chk("t4 q", int'(q_mul), 'h6B);

        // Clear coincident with a fresh underrun: set wins
        #1 underrun_clr = 1'b1;
        @(negedge clk);
        chk("t6 clr", int'(underrun), 0);
        #1 underrun_clr = 1'b0;
        repeat (8) @(negedge clk);
        #1 underrun_clr = 1'b1;
        @(negedge clk);
        chk("t6 set_wins", int'(underrun), 1);
        #1 underrun_clr = 1'b0;

        // Reset mid-stream
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        wait_stb(20, n);
        chk("t6 stb_delay", n, 10);
        chk("t6 ur_held", int'(underrun), 1);
        #1;
        @(negedge clk);
        #1;
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        chk("t6 rst_rd", int'(fifo_rd), 0);
        chk("t6 rst_i", int'(i_mul), 'h00);
        chk("t6 rst_q", int'(q_mul), 'h00);
        chk("t6 rst_stb", int'(sym_stb), 0);
        chk("t6 rst_ur", int'(underrun), 0);
        chk("t6 rst_busy", int'(busy), 0);
        #1;
        rst = 1'b0;
        ep = wr_ptr;

        // Drop run while the pair is in CAP_I
        push(8'hA1); push(8'hB2); push(8'hC3); push(8'hD4);
        sym_div = 16'd6;
        snap = rdcnt;
        run = 1'b1;
        @(negedge clk);
        chk("t5 rd_e0", int'(fifo_rd), 1);
        @(negedge clk);
        chk("t5 cap_i_rd", int'(fifo_rd), 0);
        #1 run = 1'b0;
        wait_stb(20, n);
        chk("t5 stb_delay", n, 4);
        chk("t5 i", int'(i_mul), 'hA1);
        chk("t5 q", int'(q_mul), 'hB2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 30);
        chk("t5 idle_delay", n, 7);
        chk("t5 ur", int'(underrun), 0);
        chk("t5 reads", rdcnt - snap, 2);
        chk("t5 left", wr_ptr - rd_ptr, 2);
        chk("t5 idle_i", int'(i_mul), 'h00);

        // Streaming trials: fixed then randomized divider and length
        for (int t = 0; t < 10; t++) begin
            if (t % 2 == 0) do_reset();
            if (t == 0) begin
                sym_div = 16'd4;
                pairs = 200;
            end else if (t == 1) begin
                sym_div = 16'd1;
                pairs = 30;
            end else begin
                sym_div = 16'($urandom_range(0, 12));
                pairs = $urandom_range(1, 40);
            end
            eff = (sym_div < 4) ? 4 : int'(sym_div);
            for (int k = 0; k < 2 * pairs; k++) push(8'($urandom));
            snap = rdcnt;
            run = 1'b1;
            for (int p = 0; p < pairs; p++) begin
                wait_stb(eff + 10, n);
                chk($sformatf("s%0d p%0d gap", t, p), n,
                    (p == 0) ? 6 : eff + 1);
                chk($sformatf("s%0d p%0d ur", t, p), int'(underrun), 0);
            end
            chk($sformatf("s%0d reads", t), rdcnt - snap, 2 * pairs);
            repeat (eff + 1) @(negedge clk);
            chk($sformatf("s%0d ur_end", t), int'(underrun), 1);
            chk($sformatf("s%0d idle_i", t), int'(i_mul), 'h00);
            #1 run = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (busy && n < 2 * (eff + 1) + 4);
            chk($sformatf("s%0d drained", t), int'(busy), 0);
            #1 underrun_clr = 1'b1;
            @(negedge clk);
            chk($sformatf("s%0d clr", t), int'(underrun), 0);
            #1 underrun_clr = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
